// File: rtl/iter_alu.sv
// Multi-cycle MIPS ALU: single-cycle ops finish in one cycle; MULT/MULTU/DIV/DIVU
// iterate one bit per cycle into HI/LO behind a start/busy/done handshake.
module iter_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic { IDLE, RUN } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  } op_t;

  state_t             state, state_n;
  op_t                op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               accept, is_muldiv, is_div, is_signed, launch, finish;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Iteration registers: acc = partial product high / remainder,
  // q = multiplier / dividend shifting into quotient, m = multiplicand / divisor.
  logic [WIDTH-1:0]   acc, q, m;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul, neg_res, neg_rem;

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   it_acc, it_q;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f;

  assign op        = op_t'(aluop);
  assign shamt     = a[SHAMT_W-1:0];
  assign is_muldiv = aluop[3] & aluop[2];
  assign is_div    = is_muldiv & aluop[1];
  assign is_signed = is_muldiv & ~aluop[0];
  assign accept    = start && (state == IDLE);
  assign launch    = accept && is_muldiv && !(is_div && (b == '0));
  assign finish    = (state == RUN) && (cnt == CNT_W'(1));
  assign busy      = (state == RUN);
  assign zero      = (result == '0);

  assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_NOP:  alu_res = a;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $signed(b) >>> shamt;
      OP_LUI:  alu_res = b << (WIDTH / 2);
      default: alu_res = '0;
    endcase
  end

  // One shift-add or restoring-divide step; the remainder always stays below m,
  // so the low WIDTH bits of the difference are exact when div_ge is set.
  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {acc, q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, m});
    div_diff = div_sh[WIDTH-1:0] - m;
    it_acc   = acc;
    it_q     = q;
    if (is_mul) begin
      it_acc = mul_sum[WIDTH:1];
      it_q   = {mul_sum[0], q[WIDTH-1:1]};
    end else begin
      it_acc = div_ge ? div_diff : div_sh[WIDTH-1:0];
      it_q   = {q[WIDTH-2:0], div_ge};
    end
  end

  assign prod   = {it_acc, it_q};
  assign prod_f = neg_res ? -prod : prod;
  assign quo_f  = neg_res ? -it_q : it_q;
  assign rem_f  = neg_rem ? -it_acc : it_acc;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (launch) state_n = RUN;
      RUN:     if (finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      is_mul      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        div_by_zero <= 1'b0;
        if (!is_muldiv) begin
          result <= alu_res;
          done   <= 1'b1;
        end else if (!launch) begin
          lo          <= '1;
          hi          <= a;
          result      <= '1;
          done        <= 1'b1;
          div_by_zero <= 1'b1;
        end else begin
          acc     <= '0;
          q       <= abs_a;
          m       <= abs_b;
          cnt     <= CNT_W'(WIDTH);
          is_mul  <= ~is_div;
          neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem <= is_signed & a[WIDTH-1];
        end
      end else if (state == RUN) begin
        acc <= it_acc;
        q   <= it_q;
        cnt <= cnt - CNT_W'(1);
        if (finish) begin
          done <= 1'b1;
          if (is_mul) begin
            hi     <= prod_f[2*WIDTH-1:WIDTH];
            lo     <= prod_f[WIDTH-1:0];
            result <= prod_f[WIDTH-1:0];
          end else begin
            hi     <= rem_f;
            lo     <= quo_f;
            result <= quo_f;
          end
        end
      end
    end
  end

endmodule
